// File: rtl/sa_feed_sched_if.sv
// sa_feed_sched_if: host load/start handshake and array-edge feed bundle for sa_feed_sched
interface sa_feed_sched_if #(parameter int N = 3, parameter int DW = 8);
  logic          load_valid;
  logic          load_ready;
  logic [N*DW-1:0] a_row;
  logic [N*DW-1:0] b_row;
  logic          start;
  logic [N*DW-1:0] a_out;
  logic [N*DW-1:0] b_out;
  logic          feed_valid;
  logic          clr_acc;
  logic          busy;
  logic          done;
  modport master (
    output load_valid, a_row, b_row, start,
    input  load_ready, a_out, b_out, feed_valid, clr_acc, busy, done
  );
  modport slave (
    input  load_valid, a_row, b_row, start,
    output load_ready, a_out, b_out, feed_valid, clr_acc, busy, done
  );
endinterface

// File: rtl/sa_feed_sched.sv
// sa_feed_sched: buffers one NxN A/B operand pair and feeds it diagonally skewed into a systolic array
module sa_feed_sched #(
  parameter int N         = 3,
  parameter int DW        = 8,
  parameter int DRAIN_CYC = N
) (
  input logic            i_clk,
  input logic            i_rst_n,
  sa_feed_sched_if.slave bus
);
  typedef enum logic [2:0] {IDLE, CLEAR, FEED, DRAIN, DONE} state_t;
  localparam int KW  = N > 1 ? $clog2(N) : 1;
  localparam int TW  = $clog2(2 * N);
  localparam int DCW = DRAIN_CYC > 1 ? $clog2(DRAIN_CYC) : 1;
  localparam logic [KW-1:0]  K_LAST = KW'(N - 1);
  localparam logic [TW-1:0]  T_LAST = TW'(2 * N - 2);
  localparam logic [DCW-1:0] D_LAST = DCW'(DRAIN_CYC - 1);
  state_t          state, state_n;
  logic [KW-1:0]   k, k_n;
  logic            loaded, loaded_n;
  logic [TW-1:0]   t, t_n;
  logic [DCW-1:0]  dc, dc_n;
  logic [DW-1:0]   a_buf [N][N];
  logic [DW-1:0]   b_buf [N][N];
  logic [N*DW-1:0] a_n, b_n;
  logic            accept;
  always_comb begin
    accept   = bus.load_valid && bus.load_ready;
    state_n  = state;
    k_n      = k;
    loaded_n = loaded;
    t_n      = t;
    dc_n     = dc;
    case (state)
      IDLE: begin
        if (accept) begin
          k_n      = (k == K_LAST) ? '0 : k + KW'(1);
          loaded_n = (k == K_LAST);
        end
        if (bus.start && loaded) state_n = CLEAR;
      end
      CLEAR: begin
        state_n = FEED;
        t_n     = '0;
      end
      FEED: begin
        if (t == T_LAST) begin
          state_n = (DRAIN_CYC == 0) ? DONE : DRAIN;
          dc_n    = '0;
        end else t_n = t + TW'(1);
      end
      DRAIN: begin
        if (dc == D_LAST) state_n = DONE;
        else dc_n = dc + DCW'(1);
      end
      DONE: begin
        state_n  = IDLE;
        loaded_n = 1'b0;
      end
      default: state_n = IDLE;
    endcase
    a_n = '0;
    b_n = '0;
    // Element (r,c) reaches the edge at step r+c: A on lane r, B on lane c.
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        if (state_n == FEED && int'(t_n) == r + c) begin
          a_n[r*DW +: DW] = a_buf[r][c];
          b_n[c*DW +: DW] = b_buf[r][c];
        end
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state          <= IDLE;
      k              <= '0;
      loaded         <= 1'b0;
      t              <= '0;
      dc             <= '0;
      for (int r = 0; r < N; r++)
        for (int c = 0; c < N; c++) begin
          a_buf[r][c] <= '0;
          b_buf[r][c] <= '0;
        end
      bus.load_ready <= 1'b1;
      bus.a_out      <= '0;
      bus.b_out      <= '0;
      bus.feed_valid <= 1'b0;
      bus.clr_acc    <= 1'b0;
      bus.busy       <= 1'b0;
      bus.done       <= 1'b0;
    end else begin
      state          <= state_n;
      k              <= k_n;
      loaded         <= loaded_n;
      t              <= t_n;
      dc             <= dc_n;
      for (int r = 0; r < N; r++)
        for (int c = 0; c < N; c++)
          if (accept && k == KW'(r)) begin
            a_buf[r][c] <= bus.a_row[c*DW +: DW];
            b_buf[r][c] <= bus.b_row[c*DW +: DW];
          end
      bus.load_ready <= state_n == IDLE && !loaded_n;
      bus.a_out      <= a_n;
      bus.b_out      <= b_n;
      bus.feed_valid <= state_n == FEED;
      bus.clr_acc    <= state_n == CLEAR;
      bus.busy       <= state_n inside {CLEAR, FEED, DRAIN};
      bus.done       <= state_n == DONE;
    end
  end
endmodule

// File: tb/tb_sa_feed_sched.sv
// tb_sa_feed_sched: directed checks of load, skewed feed, back-pressure, start gating and async reset
module tb_sa_feed_sched;
  typedef logic [23:0] row_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  sa_feed_sched_if #(.N(3), .DW(8)) bus ();
  sa_feed_sched #(.N(3), .DW(8), .DRAIN_CYC(3)) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus.slave)
  );
  int nvec = 0;
  int nerr = 0;
  row_t a1[3]    = '{24'h030201, 24'h060504, 24'h090807};
  row_t ident[3] = '{24'h000001, 24'h000100, 24'h010000};
  row_t a2[3]    = '{24'h302010, 24'h605040, 24'h908070};
  row_t b2[3]    = '{24'h030201, 24'h060504, 24'h090807};
  row_t ea1[5]   = '{24'h000001, 24'h000402, 24'h070503, 24'h080600, 24'h090000};
  row_t eb1[5]   = '{24'h000001, 24'h000000, 24'h000100, 24'h000000, 24'h010000};
  row_t ea2[5]   = '{24'h000010, 24'h004020, 24'h705030, 24'h806000, 24'h900000};
  row_t eb2[5]   = '{24'h000001, 24'h000204, 24'h030507, 24'h060800, 24'h090000};
  row_t rec_a[5], rec_b[5], prev_a[5], prev_b[5];
  // flag order: {clr_acc, busy, feed_valid, done, load_ready}
  function automatic logic [4:0] flags();
    return {bus.clr_acc, bus.busy, bus.feed_valid, bus.done, bus.load_ready};
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic load(input row_t ar[3], input row_t br[3]);
    for (int k = 0; k < 3; k++) begin
      nvec++;
      if (bus.load_ready !== 1'b1) begin
        nerr++;
        $display("FAIL load_ready beat %0d: got %b want 1", k, bus.load_ready);
      end
      bus.load_valid = 1'b1;
      bus.a_row = ar[k];
      bus.b_row = br[k];
      tick();
    end
    bus.load_valid = 1'b0;
  endtask
  task automatic run_check(input string nm, input row_t ea[5], input row_t eb[5]);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    nvec++;
    if (flags() !== 5'b11000 || bus.a_out !== 24'h0 || bus.b_out !== 24'h0) begin
      nerr++;
      $display("FAIL %s clear: got flags %b a %h b %h want 11000 0 0", nm, flags(), bus.a_out, bus.b_out);
    end
    for (int t = 0; t < 5; t++) begin
      tick();
      rec_a[t] = bus.a_out;
      rec_b[t] = bus.b_out;
      nvec++;
      if (flags() !== 5'b01100) begin
        nerr++;
        $display("FAIL %s feed flags t=%0d: got %b want 01100", nm, t, flags());
      end
      nvec++;
      if (bus.a_out !== ea[t]) begin
        nerr++;
        $display("FAIL %s a_out t=%0d: got %h want %h", nm, t, bus.a_out, ea[t]);
      end
      nvec++;
      if (bus.b_out !== eb[t]) begin
        nerr++;
        $display("FAIL %s b_out t=%0d: got %h want %h", nm, t, bus.b_out, eb[t]);
      end
    end
    for (int d = 0; d < 3; d++) begin
      tick();
      nvec++;
      if (flags() !== 5'b01000 || bus.a_out !== 24'h0 || bus.b_out !== 24'h0) begin
        nerr++;
        $display("FAIL %s drain %0d: got flags %b a %h b %h want 01000 0 0", nm, d, flags(), bus.a_out, bus.b_out);
      end
    end
    tick();
    nvec++;
    if (flags() !== 5'b00010) begin
      nerr++;
      $display("FAIL %s done: got flags %b want 00010", nm, flags());
    end
  endtask
  task automatic test_reset();
    #12 rst_n = 1'b1;
    tick();
    nvec++;
    if (flags() !== 5'b00001 || bus.a_out !== 24'h0 || bus.b_out !== 24'h0) begin
      nerr++;
      $display("FAIL reset: got flags %b a %h b %h want 00001 0 0", flags(), bus.a_out, bus.b_out);
    end
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    nvec++;
    if (flags() !== 5'b00001) begin
      nerr++;
      $display("FAIL start_unloaded: got flags %b want 00001", flags());
    end
    tick();
    nvec++;
    if (flags() !== 5'b00001) begin
      nerr++;
      $display("FAIL start_unloaded_late: got flags %b want 00001", flags());
    end
  endtask
  task automatic test_basic();
    load(a1, ident);
    run_check("basic", ea1, eb1);
    tick();
    nvec++;
    if (flags() !== 5'b00001) begin
      nerr++;
      $display("FAIL basic idle: got flags %b want 00001", flags());
    end
  endtask
  task automatic test_back_pressure();
    int acc = 0;
    bus.load_valid = 1'b1;
    for (int c = 0; c < 6; c++) begin
      if (acc < 3) begin
        bus.a_row = a2[acc];
        bus.b_row = b2[acc];
      end else begin
        bus.a_row = 24'hffffff;
        bus.b_row = 24'hffffff;
      end
      if (bus.load_ready === 1'b1) acc++;
      tick();
    end
    nvec++;
    if (acc !== 3 || bus.load_ready !== 1'b0) begin
      nerr++;
      $display("FAIL bp accepted: got %0d ready %b want 3 ready 0", acc, bus.load_ready);
    end
    run_check("bp", ea2, eb2);
    bus.load_valid = 1'b0;
    tick();
  endtask
  task automatic test_start_last_beat();
    bus.load_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      bus.a_row = a1[k];
      bus.b_row = ident[k];
      bus.start = (k == 2);
      tick();
    end
    bus.load_valid = 1'b0;
    bus.start = 1'b0;
    nvec++;
    if (flags() !== 5'b00000) begin
      nerr++;
      $display("FAIL start_with_last_beat: got flags %b want 00000", flags());
    end
    run_check("late_start", ea1, eb1);
    tick();
  endtask
  task automatic test_reset_mid();
    load(a1, ident);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    tick();
    nvec++;
    if (bus.feed_valid !== 1'b1 || bus.a_out !== ea1[2]) begin
      nerr++;
      $display("FAIL mid t=2: got fv %b a %h want 1 %h", bus.feed_valid, bus.a_out, ea1[2]);
    end
    #1 rst_n = 1'b0;
    #1;
    nvec++;
    if (flags() !== 5'b00001 || bus.a_out !== 24'h0 || bus.b_out !== 24'h0) begin
      nerr++;
      $display("FAIL async reset: got flags %b a %h b %h want 00001 0 0", flags(), bus.a_out, bus.b_out);
    end
    tick();
    rst_n = 1'b1;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    nvec++;
    if (flags() !== 5'b00001) begin
      nerr++;
      $display("FAIL start_after_reset: got flags %b want 00001", flags());
    end
    tick();
    nvec++;
    if (flags() !== 5'b00001) begin
      nerr++;
      $display("FAIL start_after_reset_late: got flags %b want 00001", flags());
    end
  endtask
  task automatic test_back_to_back();
    load(a2, b2);
    run_check("b2b_1", ea2, eb2);
    prev_a = rec_a;
    prev_b = rec_b;
    tick();
    load(a2, b2);
    run_check("b2b_2", ea2, eb2);
    for (int t = 0; t < 5; t++) begin
      nvec++;
      if (rec_a[t] !== prev_a[t] || rec_b[t] !== prev_b[t]) begin
        nerr++;
        $display("FAIL b2b repeat t=%0d: got %h/%h want %h/%h", t, rec_a[t], rec_b[t], prev_a[t], prev_b[t]);
      end
    end
  endtask
  initial begin
    bus.load_valid = 1'b0;
    bus.start = 1'b0;
    bus.a_row = '0;
    bus.b_row = '0;
    test_reset();
    test_basic();
    test_back_pressure();
    test_start_last_beat();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
